// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the VGA raster timing stage: default 640x480@60 porch
// and sync widths, derived totals, counter width, the default sync polarity,
// and a helper that maps a logical "sync asserted" flag to a pin level.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;
  localparam int MAX_V_ACTIVE = 512;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_SYNC_ACTIVE_HIGH = 0;
  localparam int DEF_SYNC_DELAY = 2;

  // Pin level for a sync signal given whether it is logically asserted.
  function automatic logic sync_level(input logic asserted, input int active_high);
    return (active_high != 0) ? asserted : ~asserted;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// -----------------------------------------------------------------------------
// sync_delay_line
// DEPTH-stage clock-enabled shift register used to align sync/active flags
// with the downstream fetch latency. DEPTH=0 is a pure combinational bypass.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset; every stage loads RST_VAL
//   ce    - shift enable
//   din   - WIDTH-bit input word
//   dout  - din delayed by DEPTH enabled cycles
// -----------------------------------------------------------------------------
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    // Clock, reset and enable have no function without any stages.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, ce};
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_p [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_p[i] <= RST_VAL;
      end else if (ce) begin
        stage_p[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
      end
    end

    assign dout = stage_p[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing for the text-mode pixel pipeline: horizontal/vertical
// counters, sync pulses, active-video flag and pixel position, all registered
// one cycle after the counter state. A delayed copy of {hsync, vsync, active}
// matches the character/colour fetch latency so RGB and syncs reach the DAC
// together.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   pix_ce                 - pixel clock enable; state advances only when 1
//   posx[9:0], posy[8:0]   - pixel position, 0 outside the visible area
//   active                 - visible pixel flag
//   hsync, vsync           - syncs at SYNC_ACTIVE_HIGH polarity
//   line_start/frame_start - one pix_ce-cycle pulses at h=0 / (h=0, v=0)
//   hsync_d/vsync_d/active_d - copies delayed SYNC_DELAY pix_ce cycles
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int SYNC_ACTIVE_HIGH = DEF_SYNC_ACTIVE_HIGH,
  parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       active_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic SYNC_OFF = sync_level(1'b0, SYNC_ACTIVE_HIGH);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || V_ACTIVE > MAX_V_ACTIVE ||
      SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_param_check
    $error("vga_timing_gen: timing parameters out of range");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_vis, v_vis, h_sync_win, v_sync_win, h_wrap;

  assign h_vis      = int'(h_cnt) < H_ACTIVE;
  assign v_vis      = int'(v_cnt) < V_ACTIVE;
  assign h_sync_win = (int'(h_cnt) >= H_SYNC_START) && (int'(h_cnt) < H_SYNC_END);
  // Decoded from v_cnt alone, so vsync only changes when v_cnt does (h=0).
  assign v_sync_win = (int'(v_cnt) >= V_SYNC_START) && (int'(v_cnt) < V_SYNC_END);
  assign h_wrap     = (h_cnt == H_LAST);

  // ---- stage p0: counters -> registered raster outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      posx        <= '0;
      posy        <= '0;
      active      <= 1'b0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      active      <= h_vis && v_vis;
      posx        <= h_vis ? h_cnt : '0;
      posy        <= v_vis ? v_cnt[8:0] : '0;
      hsync       <= sync_level(h_sync_win, SYNC_ACTIVE_HIGH);
      vsync       <= sync_level(v_sync_win, SYNC_ACTIVE_HIGH);
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // ---- stage p1..pN: fetch-latency alignment of {hsync, vsync, active} ----
  logic [2:0] flags_d;

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL ({SYNC_OFF, SYNC_OFF, 1'b0})
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (pix_ce),
    .din   ({hsync, vsync, active}),
    .dout  (flags_d)
  );

  assign {hsync_d, vsync_d, active_d} = flags_d;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Horizontal timing is the default 800-pixel
// line; the frame is shortened to 15 lines (8 visible, FP 2, sync 2, BP 3) so
// two full frames fit in a short run. A second instance with SYNC_DELAY=0
// shares the inputs.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HT = 800;
  localparam int VT = 15;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b0;

  logic [9:0] posx, posx0;
  logic [8:0] posy, posy0;
  logic active, hsync, vsync, line_start, frame_start, hsync_d, vsync_d, active_d;
  logic active0, hsync0, vsync0, line_start0, frame_start0, hsync_d0, vsync_d0, active_d0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .posx(posx), .posy(posy), .active(active), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start),
    .hsync_d(hsync_d), .vsync_d(vsync_d), .active_d(active_d)
  );

  vga_timing_gen #(
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .posx(posx0), .posy(posy0), .active(active0), .hsync(hsync0), .vsync(vsync0),
    .line_start(line_start0), .frame_start(frame_start0),
    .hsync_d(hsync_d0), .vsync_d(vsync_d0), .active_d(active_d0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int hs_low0, hs_first, ls_cnt, ls_bad, fs_cnt, fs_bad, vs_low, vs_first;
  int posy_max, act_cnt, trace_bad, dly_bad, d0_bad, hold_bad, ls_edges, second_ls, rbad;
  int h, ln, exp_x, exp_y;
  logic [2:0] prev1, prev2, cur;
  logic [26:0] vec, prev_vec;
  logic prev_ls;

  initial begin
    // ---- reset state ----
    rst_n = 1'b0;
    pix_ce = 1'b1;
    step();
    step();
    chk("rst_posx", int'(posx), 0);
    chk("rst_posy", int'(posy), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_line_start", int'(line_start), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_hsync_d", int'(hsync_d), 1);
    chk("rst_active_d", int'(active_d), 0);

    // ---- continuous pix_ce, two full frames ----
    rst_n = 1'b1;
    hs_low0 = 0; hs_first = -1; ls_cnt = 0; ls_bad = 0; fs_cnt = 0; fs_bad = 0;
    vs_low = 0; vs_first = -1; posy_max = 0; act_cnt = 0; trace_bad = 0;
    dly_bad = 0; d0_bad = 0;
    prev1 = 3'b110;
    prev2 = 3'b110;
    for (int t = 0; t < 2 * FR; t++) begin
      step();
      h = t % HT;
      ln = (t / HT) % VT;
      if (t == 0) begin
        chk("t0_posx", int'(posx), 0);
        chk("t0_posy", int'(posy), 0);
        chk("t0_active", int'(active), 1);
        chk("t0_line_start", int'(line_start), 1);
        chk("t0_frame_start", int'(frame_start), 1);
      end
      if (t == 639) chk("t639_posx", int'(posx), 639);
      if (t == 640) begin
        chk("t640_active", int'(active), 0);
        chk("t640_posx", int'(posx), 0);
      end
      if (t == 655) chk("t655_hsync", int'(hsync), 1);
      if (t == 656) chk("t656_hsync", int'(hsync), 0);
      if (t == 751) chk("t751_hsync", int'(hsync), 0);
      if (t == 752) chk("t752_hsync", int'(hsync), 1);
      if (t == 800) chk("t800_posy", int'(posy), 1);
      if (t < HT && !hsync) begin
        hs_low0++;
        if (hs_first < 0) hs_first = t;
      end
      if (line_start) begin
        ls_cnt++;
        if (h != 0) ls_bad++;
      end
      if (frame_start) begin
        fs_cnt++;
        if (t % FR != 0) fs_bad++;
      end
      if (!vsync) begin
        vs_low++;
        if (vs_first < 0) vs_first = t;
      end
      if (int'(posy) > posy_max) posy_max = int'(posy);
      if (active) act_cnt++;
      exp_x = (h < 640) ? h : 0;
      exp_y = (ln < 8) ? ln : 0;
      if (int'(posx) != exp_x || int'(posy) != exp_y) trace_bad++;
      cur = {hsync, vsync, active};
      if ({hsync_d, vsync_d, active_d} != prev2) dly_bad++;
      prev2 = prev1;
      prev1 = cur;
      if ({hsync0, vsync0, active0} != cur ||
          {hsync_d0, vsync_d0, active_d0} != cur ||
          posx0 != posx || posy0 != posy) d0_bad++;
    end
    chk("hsync_low_line0", hs_low0, 96);
    chk("hsync_first_low", hs_first, 656);
    chk("line_start_count", ls_cnt, 2 * VT);
    chk("line_start_misplaced", ls_bad, 0);
    chk("frame_start_count", fs_cnt, 2);
    chk("frame_start_misplaced", fs_bad, 0);
    chk("vsync_low_cycles", vs_low, 2 * 2 * HT);
    chk("vsync_first_low", vs_first, 10 * HT);
    chk("posy_max", posy_max, 7);
    chk("active_cycles", act_cnt, 2 * 640 * 8);
    chk("position_trace", trace_bad, 0);
    chk("delay2_alignment", dly_bad, 0);
    chk("delay0_passthrough", d0_bad, 0);

    // ---- pix_ce alternating 1/0 ----
    rst_n = 1'b0;
    pix_ce = 1'b1;
    step();
    rst_n = 1'b1;
    hold_bad = 0; ls_edges = 0; second_ls = -1;
    prev_ls = line_start;
    prev_vec = '0;
    for (int c = 0; c < 3400; c++) begin
      pix_ce = (c % 2 == 0);
      step();
      vec = {posx, posy, active, hsync, vsync, line_start, frame_start,
             hsync_d, vsync_d, active_d};
      if (!pix_ce && vec != prev_vec) hold_bad++;
      if (line_start && !prev_ls) begin
        if (ls_edges == 1) second_ls = c;
        ls_edges++;
      end
      prev_ls = line_start;
      prev_vec = vec;
      if (c == 0) chk("alt_c0_frame_start", int'(frame_start), 1);
      if (c == 10) chk("alt_c10_posx", int'(posx), 5);
      if (c == 11) chk("alt_c11_posx_hold", int'(posx), 5);
    end
    chk("alt_hold", hold_bad, 0);
    chk("alt_line_period", second_ls, 2 * HT);
    chk("alt_line_edges", ls_edges, 3);

    // ---- reset mid-frame at (300, 5) ----
    rst_n = 1'b0;
    pix_ce = 1'b1;
    step();
    rst_n = 1'b1;
    for (int t = 0; t <= 5 * HT + 300; t++) step();
    chk("pre_rst_posx", int'(posx), 300);
    chk("pre_rst_posy", int'(posy), 5);
    chk("pre_rst_active_d", int'(active_d), 1);
    rst_n = 1'b0;
    rbad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (active || !hsync || !vsync || !hsync_d || !vsync_d || active_d ||
          posx != 10'd0 || posy != 9'd0 || line_start || frame_start) rbad++;
    end
    chk("mid_rst_idle", rbad, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_posx", int'(posx), 0);
    chk("post_rst_posy", int'(posy), 0);
    chk("post_rst_active", int'(active), 1);
    chk("post_rst_frame_start", int'(frame_start), 1);
    chk("post_rst_hsync_d0", int'(hsync_d), 1);
    chk("post_rst_active_d0", int'(active_d), 0);
    step();
    chk("post_rst_hsync_d1", int'(hsync_d), 1);
    chk("post_rst_active_d1", int'(active_d), 0);
    step();
    chk("post_rst_active_d2", int'(active_d), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
